// File: rtl/i2c_master_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_fsm_if
// Brief    : Host request/response handshake of the single-byte I2C master.
// Revision : 1.0 - initial release
// ============================================================================
interface i2c_master_fsm_if;
   logic       start_in;
   logic [6:0] addr_in;
   logic       rw_in;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       busy_out;
   logic       done_out;
   logic       ack_err_out;

   // The host issues requests (master); the I2C engine serves them (slave).
   modport master (output start_in, addr_in, rw_in, data_in,
                   input  data_out, busy_out, done_out, ack_err_out);
   modport slave  (input  start_in, addr_in, rw_in, data_in,
                   output data_out, busy_out, done_out, ack_err_out);
endinterface
`default_nettype wire

// File: rtl/i2c_master_fsm.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_fsm
// Brief    : Single-byte I2C master: START, address, ACK, one data byte, STOP.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_master_fsm #(
   parameter int CLK_DIV = 4
) (
   input  logic            clk_in,
   input  logic            rst_in,
   i2c_master_fsm_if.slave host,
   output logic            i2c_scl,
   inout  wire             i2c_sda
);
   localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_ADDR  = 3'd2,
      S_ACK   = 3'd3,
      S_WRITE = 3'd4,
      S_READ  = 3'd5,
      S_STOP  = 3'd6
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] div_q, div_d;
   logic [2:0] qtr_q, qtr_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] addr_byte_q, addr_byte_d;
   logic [7:0] wdata_q, wdata_d;
   logic [7:0] rdata_q, rdata_d;
   logic [7:0] data_out_q, data_out_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       ack_err_q, ack_err_d;
   logic       scl_q, scl_d;
   logic       sda_en_q, sda_en_d;
   logic       sda_out_q, sda_out_d;
   logic       w_tick, w_accept, w_sda_in, w_slot_end;

   assign w_tick     = (div_q == c_DIV_LAST);
   assign w_accept   = host.start_in && !busy_q;
   assign w_sda_in   = i2c_sda;
   assign w_slot_end = w_tick && (qtr_q == 3'd3);

   always_comb begin
      state_d     = state_q;
      div_d       = w_tick ? 8'd0 : div_q + 8'd1;
      qtr_d       = w_tick ? qtr_q + 3'd1 : qtr_q;
      bit_d       = bit_q;
      addr_byte_d = addr_byte_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      data_out_d  = data_out_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      ack_err_d   = ack_err_q;
      case (state_q)
         S_IDLE: begin
            div_d = 8'd0;
            qtr_d = 3'd0;
            if (w_accept) begin
               state_d     = S_START;
               bit_d       = 3'd0;
               addr_byte_d = {host.addr_in, host.rw_in};
               wdata_d     = host.data_in;
               ack_err_d   = 1'b0;
               busy_d      = 1'b1;
            end
         end
         S_START: if (w_slot_end) begin
            state_d = S_ADDR;
            qtr_d   = 3'd0;
            bit_d   = 3'd0;
         end
         S_ADDR: if (w_slot_end) begin
            qtr_d = 3'd0;
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_ACK;
         end
         S_ACK: if (w_slot_end) begin
            qtr_d = 3'd0;
            bit_d = 3'd0;
            if (w_sda_in) begin
               ack_err_d = 1'b1;
               state_d   = S_STOP;
            end else begin
               state_d = addr_byte_q[0] ? S_READ : S_WRITE;
            end
         end
         S_WRITE, S_READ: if (w_slot_end) begin
            qtr_d = 3'd0;
            bit_d = bit_q + 3'd1;
            if (state_q == S_READ) rdata_d = {rdata_q[6:0], w_sda_in};
            if (bit_q == 3'd7) state_d = S_STOP;
         end
         S_STOP: if (w_tick && (qtr_q == 3'd7)) begin
            state_d = S_IDLE;
            qtr_d   = 3'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (addr_byte_q[0] && !ack_err_q) data_out_d = rdata_q;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Pin levels are decoded from the next state so they change on quarter entry.
   always_comb begin
      scl_d     = 1'b1;
      sda_en_d  = 1'b1;
      sda_out_d = 1'b1;
      case (state_d)
         S_START: begin
            scl_d     = ~qtr_d[1];
            sda_out_d = (qtr_d == 3'd0);
         end
         S_ADDR: begin
            scl_d     = qtr_d[1];
            sda_out_d = addr_byte_d[3'd7 - bit_d];
         end
         S_WRITE: begin
            scl_d     = qtr_d[1];
            sda_out_d = wdata_d[3'd7 - bit_d];
         end
         S_ACK, S_READ: begin
            scl_d    = qtr_d[1];
            sda_en_d = 1'b0;
         end
         S_STOP: begin
            // Released dummy clock first so the slave drops its driver, then stop edge.
            case (qtr_d)
               3'd0, 3'd1: begin scl_d = 1'b0; sda_en_d = 1'b0; end
               3'd2, 3'd3: sda_en_d = 1'b0;
               3'd4:       begin scl_d = 1'b0; sda_out_d = 1'b0; end
               3'd5:       sda_out_d = 1'b0;
               default:    ;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= S_IDLE;
         div_q       <= 8'd0;
         qtr_q       <= 3'd0;
         bit_q       <= 3'd0;
         addr_byte_q <= 8'd0;
         wdata_q     <= 8'd0;
         rdata_q     <= 8'd0;
         data_out_q  <= 8'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ack_err_q   <= 1'b0;
         scl_q       <= 1'b1;
         sda_en_q    <= 1'b1;
         sda_out_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         qtr_q       <= qtr_d;
         bit_q       <= bit_d;
         addr_byte_q <= addr_byte_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         data_out_q  <= data_out_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ack_err_q   <= ack_err_d;
         scl_q       <= scl_d;
         sda_en_q    <= sda_en_d;
         sda_out_q   <= sda_out_d;
      end
   end

   assign i2c_scl          = scl_q;
   assign i2c_sda          = sda_en_q ? sda_out_q : 1'bz;
   assign host.data_out    = data_out_q;
   assign host.busy_out    = busy_q;
   assign host.done_out    = done_q;
   assign host.ack_err_out = ack_err_q;
endmodule
`default_nettype wire

// File: tb/tb_i2c_master_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_master_fsm
// Brief    : Self-checking bench with a bus-level I2C slave and frame model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_master_fsm;
   localparam int DIV       = 4;
   localparam int OK_LAT    = 1 + 80 * DIV;
   localparam int NACK_LAT  = 1 + 48 * DIV;
   localparam int LAT_LIMIT = 2 * OK_LAT;
   localparam int P_IDLE = 0, P_ADDR = 1, P_ACKWAIT = 2, P_ACK = 3, P_ACKDONE = 4,
                  P_WR = 5, P_RD = 6, P_RDEND = 7, P_DONE = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic scl;
   wire  sda;
   logic slv_low = 1'b0;

   pullup (sda);
   assign sda = slv_low ? 1'b0 : 1'bz;

   i2c_master_fsm_if host_if();

   i2c_master_fsm #(.CLK_DIV(DIV)) dut (
      .clk_in  (clk),
      .rst_in  (rst),
      .host    (host_if),
      .i2c_scl (scl),
      .i2c_sda (sda)
   );

   always #5 clk = ~clk;

   int check_cnt = 0;
   int pass_cnt  = 0;

   // Bus-level slave: decodes START/STOP and clock edges from the pins only.
   logic       slv_present = 1'b1;
   logic [7:0] slv_rd_byte = 8'h00;
   logic [7:0] addr_seen[$];
   logic [7:0] wr_seen[$];
   int         scl_rises = 0;
   int         phase = P_IDLE;
   int         nbits = 0;
   logic [7:0] shreg = 8'h00;
   logic       rd_mode = 1'b0;
   logic       scl_prev = 1'b1;
   logic       sda_prev = 1'b1;

   always @(negedge clk) begin
      if (rst) begin
         phase   <= P_IDLE;
         slv_low <= 1'b0;
         nbits   <= 0;
      end else if (scl_prev && scl && sda_prev && !sda) begin
         phase   <= P_ADDR;
         nbits   <= 0;
         slv_low <= 1'b0;
      end else if (scl_prev && scl && !sda_prev && sda) begin
         phase   <= P_IDLE;
         slv_low <= 1'b0;
      end else if (!scl_prev && scl) begin
         scl_rises <= scl_rises + 1;
         case (phase)
            P_ADDR, P_WR: begin
               shreg <= {shreg[6:0], sda};
               nbits <= nbits + 1;
               if (nbits == 7) begin
                  if (phase == P_ADDR) begin
                     addr_seen.push_back({shreg[6:0], sda});
                     rd_mode <= sda;
                     phase   <= P_ACKWAIT;
                  end else begin
                     wr_seen.push_back({shreg[6:0], sda});
                     phase <= P_DONE;
                  end
               end
            end
            P_ACK: phase <= P_ACKDONE;
            P_RD: begin
               nbits <= nbits + 1;
               if (nbits == 7) phase <= P_RDEND;
            end
            default: ;
         endcase
      end else if (scl_prev && !scl) begin
         case (phase)
            P_ACKWAIT: begin
               if (slv_present) begin
                  slv_low <= 1'b1;
                  phase   <= P_ACK;
               end else begin
                  phase <= P_DONE;
               end
            end
            P_ACKDONE: begin
               nbits <= 0;
               if (rd_mode) begin
                  phase   <= P_RD;
                  slv_low <= !slv_rd_byte[7];
               end else begin
                  phase   <= P_WR;
                  slv_low <= 1'b0;
               end
            end
            P_RD:    slv_low <= !slv_rd_byte[3'(7 - nbits)];
            P_RDEND: begin slv_low <= 1'b0; phase <= P_DONE; end
            default: ;
         endcase
      end
      scl_prev <= scl;
      sda_prev <= sda;
   end

   // Reference view of the block: what data_out must hold after each transaction.
   logic [7:0] model_dout = 8'h00;

   task automatic run_txn(input logic [6:0] a, input logic rw, input logic [7:0] d,
                          output int lat, output logic busy1);
      @(negedge clk);
      host_if.addr_in  = a;
      host_if.rw_in    = rw;
      host_if.data_in  = d;
      host_if.start_in = 1'b1;
      @(negedge clk);
      host_if.start_in = 1'b0;
      host_if.data_in  = 8'(~d);
      lat   = 1;
      busy1 = host_if.busy_out;
      while (host_if.done_out !== 1'b1 && lat < LAT_LIMIT) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_cnt++; if (scl !== 1'b1) $display("FAIL reset_scl: got %b want 1", scl); else pass_cnt++;
      check_cnt++; if (sda !== 1'b1) $display("FAIL reset_sda: got %b want 1", sda); else pass_cnt++;
      check_cnt++; if (host_if.busy_out !== 1'b0) $display("FAIL reset_busy: got %b want 0", host_if.busy_out); else pass_cnt++;
      check_cnt++; if (host_if.done_out !== 1'b0) $display("FAIL reset_done: got %b want 0", host_if.done_out); else pass_cnt++;
      check_cnt++; if (host_if.ack_err_out !== 1'b0) $display("FAIL reset_ack_err: got %b want 0", host_if.ack_err_out); else pass_cnt++;
      check_cnt++; if (host_if.data_out !== 8'h00) $display("FAIL reset_data_out: got %h want 00", host_if.data_out); else pass_cnt++;
      rst = 1'b0;
      model_dout = 8'h00;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_write();
      int lat, r0, w0;
      logic b1;
      slv_present = 1'b1;
      r0 = scl_rises; w0 = wr_seen.size();
      run_txn(7'h2A, 1'b0, 8'hA5, lat, b1);
      check_cnt++; if (lat !== OK_LAT) $display("FAIL write_latency: got %0d want %0d", lat, OK_LAT); else pass_cnt++;
      check_cnt++; if (b1 !== 1'b1) $display("FAIL write_busy_first: got %b want 1", b1); else pass_cnt++;
      check_cnt++; if (host_if.busy_out !== 1'b0) $display("FAIL write_busy_done: got %b want 0", host_if.busy_out); else pass_cnt++;
      check_cnt++; if (host_if.ack_err_out !== 1'b0) $display("FAIL write_ack_err: got %b want 0", host_if.ack_err_out); else pass_cnt++;
      check_cnt++; if (addr_seen[$] !== 8'h54) $display("FAIL write_addr_byte: got %h want 54", addr_seen[$]); else pass_cnt++;
      check_cnt++; if (wr_seen.size() != w0 + 1 || wr_seen[$] !== 8'hA5)
         $display("FAIL write_data_byte: got %h (count %0d) want A5 (count %0d)", wr_seen[$], wr_seen.size(), w0 + 1); else pass_cnt++;
      @(negedge clk);
      check_cnt++; if (scl_rises - r0 != 19) $display("FAIL write_scl_pulses: got %0d want 19", scl_rises - r0); else pass_cnt++;
      check_cnt++; if (host_if.done_out !== 1'b0) $display("FAIL write_done_width: got %b want 0", host_if.done_out); else pass_cnt++;
   endtask

   task automatic test_read();
      int lat;
      logic b1;
      slv_present = 1'b1;
      slv_rd_byte = 8'h3C;
      run_txn(7'h2A, 1'b1, 8'h00, lat, b1);
      model_dout = 8'h3C;
      check_cnt++; if (lat !== OK_LAT) $display("FAIL read_latency: got %0d want %0d", lat, OK_LAT); else pass_cnt++;
      check_cnt++; if (host_if.data_out !== model_dout) $display("FAIL read_data: got %h want %h", host_if.data_out, model_dout); else pass_cnt++;
      check_cnt++; if (addr_seen[$] !== 8'h55) $display("FAIL read_addr_byte: got %h want 55", addr_seen[$]); else pass_cnt++;
   endtask

   task automatic test_nack();
      int lat, r0, w0;
      logic b1;
      slv_present = 1'b0;
      r0 = scl_rises; w0 = wr_seen.size();
      run_txn(7'h11, 1'b0, 8'h77, lat, b1);
      check_cnt++; if (lat !== NACK_LAT) $display("FAIL nack_latency: got %0d want %0d", lat, NACK_LAT); else pass_cnt++;
      check_cnt++; if (host_if.ack_err_out !== 1'b1) $display("FAIL nack_ack_err: got %b want 1", host_if.ack_err_out); else pass_cnt++;
      check_cnt++; if (host_if.data_out !== model_dout) $display("FAIL nack_data_out: got %h want %h", host_if.data_out, model_dout); else pass_cnt++;
      check_cnt++; if (wr_seen.size() != w0) $display("FAIL nack_no_write: got %0d want %0d", wr_seen.size(), w0); else pass_cnt++;
      @(negedge clk);
      check_cnt++; if (scl_rises - r0 != 11) $display("FAIL nack_scl_pulses: got %0d want 11", scl_rises - r0); else pass_cnt++;
      repeat (5) @(negedge clk);
      check_cnt++; if (host_if.ack_err_out !== 1'b1) $display("FAIL nack_ack_err_held: got %b want 1", host_if.ack_err_out); else pass_cnt++;
      slv_present = 1'b1;
   endtask

   task automatic test_busy_ignore();
      int lat, dones, w0;
      w0 = wr_seen.size();
      @(negedge clk);
      host_if.addr_in = 7'h2A; host_if.rw_in = 1'b0; host_if.data_in = 8'h66;
      host_if.start_in = 1'b1;
      @(negedge clk);
      host_if.start_in = 1'b0;
      lat = 1; dones = 0;
      while (host_if.done_out !== 1'b1 && lat < LAT_LIMIT) begin
         @(negedge clk);
         lat++;
         if (lat == 60) begin
            host_if.addr_in = 7'h11; host_if.rw_in = 1'b1; host_if.data_in = 8'hFF;
            host_if.start_in = 1'b1;
         end else begin
            host_if.start_in = 1'b0;
         end
      end
      check_cnt++; if (lat !== OK_LAT) $display("FAIL busy_ign_latency: got %0d want %0d", lat, OK_LAT); else pass_cnt++;
      for (int i = 0; i < 3 * OK_LAT; i++) begin
         if (host_if.done_out === 1'b1) dones++;
         @(negedge clk);
      end
      check_cnt++; if (dones != 1) $display("FAIL busy_ign_done_count: got %0d want 1", dones); else pass_cnt++;
      check_cnt++; if (wr_seen.size() != w0 + 1 || wr_seen[$] !== 8'h66)
         $display("FAIL busy_ign_byte: got %h (count %0d) want 66 (count %0d)", wr_seen[$], wr_seen.size(), w0 + 1); else pass_cnt++;
   endtask

   task automatic test_reset_mid_addr();
      int lat, w0;
      logic b1;
      @(negedge clk);
      host_if.addr_in = 7'h2A; host_if.rw_in = 1'b0; host_if.data_in = 8'hC3;
      host_if.start_in = 1'b1;
      @(negedge clk);
      host_if.start_in = 1'b0;
      // Slot 3 of the address byte, SCL high.
      repeat ((4 + 3 * 4 + 2) * DIV + 1) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check_cnt++; if (scl !== 1'b1) $display("FAIL rst_mid_scl: got %b want 1", scl); else pass_cnt++;
      check_cnt++; if (sda !== 1'b1) $display("FAIL rst_mid_sda: got %b want 1", sda); else pass_cnt++;
      check_cnt++; if (host_if.busy_out !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", host_if.busy_out); else pass_cnt++;
      model_dout = 8'h00;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      w0 = wr_seen.size();
      run_txn(7'h2A, 1'b0, 8'h5A, lat, b1);
      check_cnt++; if (lat !== OK_LAT) $display("FAIL rst_mid_next_latency: got %0d want %0d", lat, OK_LAT); else pass_cnt++;
      check_cnt++; if (wr_seen.size() != w0 + 1 || wr_seen[$] !== 8'h5A)
         $display("FAIL rst_mid_next_byte: got %h (count %0d) want 5A (count %0d)", wr_seen[$], wr_seen.size(), w0 + 1); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int lat, w0;
      logic b1;
      w0 = wr_seen.size();
      run_txn(7'h2A, 1'b0, 8'h01, lat, b1);
      check_cnt++; if (lat !== OK_LAT) $display("FAIL b2b_first_latency: got %0d want %0d", lat, OK_LAT); else pass_cnt++;
      // Request issued inside the done cycle itself.
      host_if.data_in = 8'h02; host_if.start_in = 1'b1;
      @(negedge clk);
      host_if.start_in = 1'b0;
      lat = 1;
      while (host_if.done_out !== 1'b1 && lat < LAT_LIMIT) begin
         @(negedge clk);
         lat++;
      end
      check_cnt++; if (lat !== OK_LAT) $display("FAIL b2b_second_latency: got %0d want %0d", lat, OK_LAT); else pass_cnt++;
      check_cnt++; if (wr_seen.size() != w0 + 2) $display("FAIL b2b_count: got %0d want %0d", wr_seen.size() - w0, 2);
      else if (wr_seen[w0] !== 8'h01 || wr_seen[w0 + 1] !== 8'h02)
         $display("FAIL b2b_order: got %h,%h want 01,02", wr_seen[w0], wr_seen[w0 + 1]);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int lat, r0, w0, exp_lat, exp_rises;
      logic b1;
      logic [6:0] a;
      logic rw;
      logic [7:0] d;
      for (int n = 0; n < 8; n++) begin
         a  = 7'($urandom_range(0, 127));
         rw = 1'($urandom_range(0, 1));
         d  = 8'($urandom_range(0, 255));
         slv_present = ($urandom_range(0, 3) != 0);
         slv_rd_byte = 8'($urandom_range(0, 255));
         r0 = scl_rises; w0 = wr_seen.size();
         exp_lat   = slv_present ? OK_LAT : NACK_LAT;
         exp_rises = slv_present ? 19 : 11;
         if (slv_present && rw) model_dout = slv_rd_byte;
         run_txn(a, rw, d, lat, b1);
         check_cnt++; if (lat !== exp_lat) $display("FAIL rnd%0d_latency: got %0d want %0d", n, lat, exp_lat); else pass_cnt++;
         check_cnt++; if (host_if.ack_err_out !== !slv_present) $display("FAIL rnd%0d_ack_err: got %b want %b", n, host_if.ack_err_out, !slv_present); else pass_cnt++;
         check_cnt++; if (host_if.data_out !== model_dout) $display("FAIL rnd%0d_data_out: got %h want %h", n, host_if.data_out, model_dout); else pass_cnt++;
         check_cnt++; if (addr_seen[$] !== {a, rw}) $display("FAIL rnd%0d_addr_byte: got %h want %h", n, addr_seen[$], {a, rw}); else pass_cnt++;
         if (slv_present && !rw) begin
            check_cnt++; if (wr_seen.size() != w0 + 1 || wr_seen[$] !== d)
               $display("FAIL rnd%0d_wr_byte: got %h want %h", n, wr_seen[$], d); else pass_cnt++;
         end else begin
            check_cnt++; if (wr_seen.size() != w0) $display("FAIL rnd%0d_no_wr: got %0d want %0d", n, wr_seen.size(), w0); else pass_cnt++;
         end
         @(negedge clk);
         check_cnt++; if (scl_rises - r0 != exp_rises) $display("FAIL rnd%0d_scl_pulses: got %0d want %0d", n, scl_rises - r0, exp_rises); else pass_cnt++;
      end
      slv_present = 1'b1;
   endtask

   initial begin
      host_if.start_in = 1'b0;
      host_if.addr_in  = 7'h00;
      host_if.rw_in    = 1'b0;
      host_if.data_in  = 8'h00;
      test_reset();
      test_write();
      test_read();
      test_nack();
      test_busy_ignore();
      test_reset_mid_addr();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end
endmodule
`default_nettype wire
